// File: rtl/bellek_hakemi_pkg.sv
// Shared types and constants for the L1 data-cache port arbiter.
// FSM state encodings, requester indices and a one-hot helper.
package bellek_hakemi_pkg;

   typedef enum logic [1:0] {
      BOSTA  = 2'd0,
      GONDER = 2'd1,
      BEKLE  = 2'd2
   } durum_t;

   localparam logic ISTEKCI_BIB           = 1'b0;
   localparam logic ISTEKCI_HATA_AYIKLAMA = 1'b1;

   function automatic logic [1:0] tek_sicak(input logic sahip);
      logic [1:0] sonuc;
      sonuc        = 2'b00;
      sonuc[sahip] = 1'b1;
      return sonuc;
   endfunction

endpackage

// File: rtl/bellek_hakemi_if.sv
// Requester-side bus of the arbiter: two request channels in, routed responses out.
// master = requesters (load/store unit, debug/DMA), slave = arbiter.
interface bellek_hakemi_if #(
   parameter int ADRES_BIT = 32,
   parameter int VERI_BIT  = 32
);
   logic [1:0]            istek_gecerli_i;
   logic [1:0]            istek_yaz_i;
   logic [ADRES_BIT-1:0]  istek_adres0_i;
   logic [ADRES_BIT-1:0]  istek_adres1_i;
   logic [VERI_BIT-1:0]   istek_veri0_i;
   logic [VERI_BIT-1:0]   istek_veri1_i;
   logic [VERI_BIT/8-1:0] istek_maske0_i;
   logic [VERI_BIT/8-1:0] istek_maske1_i;
   logic [1:0]            istek_hazir_o;
   logic [1:0]            yanit_gecerli_o;
   logic [VERI_BIT-1:0]   yanit_veri_o;

   modport master (
      output istek_gecerli_i, istek_yaz_i,
      output istek_adres0_i, istek_adres1_i,
      output istek_veri0_i, istek_veri1_i,
      output istek_maske0_i, istek_maske1_i,
      input  istek_hazir_o, yanit_gecerli_o, yanit_veri_o
   );

   modport slave (
      input  istek_gecerli_i, istek_yaz_i,
      input  istek_adres0_i, istek_adres1_i,
      input  istek_veri0_i, istek_veri1_i,
      input  istek_maske0_i, istek_maske1_i,
      output istek_hazir_o, yanit_gecerli_o, yanit_veri_o
   );
endinterface

// File: rtl/bellek_hakemi_rr.sv
// Two-input round-robin grant: on a tie the requester that did not win last time is chosen.
// Pure combinational; the last-winner pointer is held by the parent.
module bellek_hakemi_rr (
   input  logic [1:0] req,
   input  logic       son,
   input  logic       enable,
   output logic [1:0] grant
);

   // grant selection
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = son ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end else begin
         grant = 2'b00;
      end
   end

endmodule

// File: rtl/bellek_hakemi.sv
// Arbitrates the single L1 data-cache port between the load/store unit and a debug/DMA master.
// One transaction in flight; responses are routed back to the issuing requester.
module bellek_hakemi
   import bellek_hakemi_pkg::*;
#(
   parameter int ADRES_BIT = 32,
   parameter int VERI_BIT  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   bellek_hakemi_if.slave        istek,
   output logic                  l1c_istek_gecerli_o,
   output logic                  l1c_yaz_gecerli_o,
   output logic [ADRES_BIT-1:0]  l1c_veri_adres_o,
   output logic [VERI_BIT-1:0]   l1c_yaz_veri_o,
   output logic [VERI_BIT/8-1:0] l1c_veri_maske_o,
   input  logic                  l1c_stall_i,
   input  logic                  l1c_oku_gecerli_i,
   input  logic [VERI_BIT-1:0]   l1c_oku_veri_i
);

   localparam int MASKE_BIT = VERI_BIT / 8;

   durum_t                durum_r;
   durum_t                durum_sonraki_s;
   logic                  son_r;
   logic                  sahip_r;
   logic                  yaz_r;
   logic [ADRES_BIT-1:0]  adres_r;
   logic [VERI_BIT-1:0]   veri_r;
   logic [MASKE_BIT-1:0]  maske_r;
   logic [1:0]            yanit_gecerli_r;
   logic [VERI_BIT-1:0]   yanit_veri_r;
   logic [1:0]            kazanan_s;
   logic                  kabul_s;
   logic                  secim_s;

   bellek_hakemi_rr u_rr (
      .req    (istek.istek_gecerli_i),
      .son    (son_r),
      .enable ((durum_r == BOSTA) && !rst_i),
      .grant  (kazanan_s)
   );

   assign kabul_s = |kazanan_s;
   assign secim_s = kazanan_s[ISTEKCI_HATA_AYIKLAMA];

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_r <= BOSTA;
      end else begin
         durum_r <= durum_sonraki_s;
      end
   end

   // next-state logic
   always_comb begin
      durum_sonraki_s = durum_r;
      case (durum_r)
         BOSTA:   durum_sonraki_s = kabul_s ? GONDER : BOSTA;
         GONDER: begin
            if (!l1c_stall_i) begin
               durum_sonraki_s = yaz_r ? BOSTA : BEKLE;
            end else begin
               durum_sonraki_s = GONDER;
            end
         end
         BEKLE:   durum_sonraki_s = l1c_oku_gecerli_i ? BOSTA : BEKLE;
         default: durum_sonraki_s = BOSTA;
      endcase
   end

   // outputs toward L1 and the combinational accept strobe
   always_comb begin
      istek.istek_hazir_o = kazanan_s;
      l1c_istek_gecerli_o = 1'b0;
      l1c_yaz_gecerli_o   = 1'b0;
      l1c_veri_adres_o    = {ADRES_BIT{1'b0}};
      l1c_yaz_veri_o      = {VERI_BIT{1'b0}};
      l1c_veri_maske_o    = {MASKE_BIT{1'b0}};
      if (durum_r == GONDER) begin
         l1c_istek_gecerli_o = 1'b1;
         l1c_yaz_gecerli_o   = yaz_r;
         l1c_veri_adres_o    = adres_r;
         l1c_yaz_veri_o      = veri_r;
         l1c_veri_maske_o    = maske_r;
      end else begin
         l1c_istek_gecerli_o = 1'b0;
      end
   end

   // latch the accepted request; son_r=1 after reset lets port 0 win the first tie
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         son_r   <= 1'b1;
         sahip_r <= ISTEKCI_BIB;
         yaz_r   <= 1'b0;
         adres_r <= {ADRES_BIT{1'b0}};
         veri_r  <= {VERI_BIT{1'b0}};
         maske_r <= {MASKE_BIT{1'b0}};
      end else if (kabul_s) begin
         son_r   <= secim_s;
         sahip_r <= secim_s;
         yaz_r   <= istek.istek_yaz_i[secim_s];
         adres_r <= secim_s ? istek.istek_adres1_i : istek.istek_adres0_i;
         veri_r  <= secim_s ? istek.istek_veri1_i  : istek.istek_veri0_i;
         maske_r <= secim_s ? istek.istek_maske1_i : istek.istek_maske0_i;
      end
   end

   // response pulse and data; read data holds between loads, store ack clears it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         yanit_gecerli_r <= 2'b00;
         yanit_veri_r    <= {VERI_BIT{1'b0}};
      end else begin
         yanit_gecerli_r <= 2'b00;
         if ((durum_r == GONDER) && !l1c_stall_i && yaz_r) begin
            yanit_gecerli_r <= tek_sicak(sahip_r);
            yanit_veri_r    <= {VERI_BIT{1'b0}};
         end else if ((durum_r == BEKLE) && l1c_oku_gecerli_i) begin
            yanit_gecerli_r <= tek_sicak(sahip_r);
            yanit_veri_r    <= l1c_oku_veri_i;
         end
      end
   end

   assign istek.yanit_gecerli_o = yanit_gecerli_r;
   assign istek.yanit_veri_o    = yanit_veri_r;

endmodule

// File: tb/tb_bellek_hakemi.sv
// Directed bench for bellek_hakemi: inputs change and outputs are sampled on the falling edge.
module tb_bellek_hakemi;

   logic        clk_i;
   logic        rst_i;
   logic        l1c_istek_gecerli_o;
   logic        l1c_yaz_gecerli_o;
   logic [31:0] l1c_veri_adres_o;
   logic [31:0] l1c_yaz_veri_o;
   logic [3:0]  l1c_veri_maske_o;
   logic        l1c_stall_i;
   logic        l1c_oku_gecerli_i;
   logic [31:0] l1c_oku_veri_i;

   int toplam;
   int gecen;

   bellek_hakemi_if #(.ADRES_BIT(32), .VERI_BIT(32)) bus ();

   bellek_hakemi #(.ADRES_BIT(32), .VERI_BIT(32)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .istek               (bus),
      .l1c_istek_gecerli_o (l1c_istek_gecerli_o),
      .l1c_yaz_gecerli_o   (l1c_yaz_gecerli_o),
      .l1c_veri_adres_o    (l1c_veri_adres_o),
      .l1c_yaz_veri_o      (l1c_yaz_veri_o),
      .l1c_veri_maske_o    (l1c_veri_maske_o),
      .l1c_stall_i         (l1c_stall_i),
      .l1c_oku_gecerli_i   (l1c_oku_gecerli_i),
      .l1c_oku_veri_i      (l1c_oku_veri_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic kontrol_et(input string etiket, input logic [63:0] gozlenen,
                             input logic [63:0] beklenen);
      toplam = toplam + 1;
      if (gozlenen === beklenen) begin
         gecen = gecen + 1;
      end else begin
         $display("FAIL %s: gozlenen=%0h beklenen=%0h", etiket, gozlenen, beklenen);
      end
   endtask

   task automatic tik();
      @(negedge clk_i);
   endtask

   task automatic hepsi_sifir(input string etiket);
      kontrol_et({etiket, "_hazir"},  64'(bus.istek_hazir_o),   64'd0);
      kontrol_et({etiket, "_yanit"},  64'(bus.yanit_gecerli_o), 64'd0);
      kontrol_et({etiket, "_rveri"},  64'(bus.yanit_veri_o),    64'd0);
      kontrol_et({etiket, "_l1gec"},  64'(l1c_istek_gecerli_o), 64'd0);
      kontrol_et({etiket, "_l1yaz"},  64'(l1c_yaz_gecerli_o),   64'd0);
      kontrol_et({etiket, "_l1adr"},  64'(l1c_veri_adres_o),    64'd0);
      kontrol_et({etiket, "_l1ver"},  64'(l1c_yaz_veri_o),      64'd0);
      kontrol_et({etiket, "_l1msk"},  64'(l1c_veri_maske_o),    64'd0);
   endtask

   initial begin
      toplam = 0;
      gecen  = 0;
      rst_i  = 1'b1;
      bus.istek_gecerli_i = 2'b00;
      bus.istek_yaz_i     = 2'b00;
      bus.istek_adres0_i  = 32'h0;
      bus.istek_adres1_i  = 32'h0;
      bus.istek_veri0_i   = 32'h0;
      bus.istek_veri1_i   = 32'h0;
      bus.istek_maske0_i  = 4'h0;
      bus.istek_maske1_i  = 4'h0;
      l1c_stall_i       = 1'b0;
      l1c_oku_gecerli_i = 1'b0;
      l1c_oku_veri_i    = 32'h0;

      tik();
      tik();
      hepsi_sifir("reset");
      rst_i = 1'b0;

      // single load from port 0, data two cycles after accept
      bus.istek_gecerli_i = 2'b01;
      bus.istek_adres0_i  = 32'h100;
      #1;
      kontrol_et("t1_hazir", 64'(bus.istek_hazir_o), 64'h1);
      tik();
      bus.istek_gecerli_i = 2'b00;
      kontrol_et("t1_l1gec", 64'(l1c_istek_gecerli_o), 64'h1);
      kontrol_et("t1_l1yaz", 64'(l1c_yaz_gecerli_o), 64'h0);
      kontrol_et("t1_l1adr", 64'(l1c_veri_adres_o), 64'h100);
      tik();
      kontrol_et("t1_bekle_l1gec", 64'(l1c_istek_gecerli_o), 64'h0);
      l1c_oku_gecerli_i = 1'b1;
      l1c_oku_veri_i    = 32'hDEADBEEF;
      tik();
      l1c_oku_gecerli_i = 1'b0;
      kontrol_et("t1_yanit", 64'(bus.yanit_gecerli_o), 64'h1);
      kontrol_et("t1_rveri", 64'(bus.yanit_veri_o), 64'hDEADBEEF);
      tik();
      kontrol_et("t1_darbe", 64'(bus.yanit_gecerli_o), 64'h0);
      kontrol_et("t1_tut",   64'(bus.yanit_veri_o), 64'hDEADBEEF);

      // store from port 1 with a 3-cycle stall
      bus.istek_gecerli_i = 2'b10;
      bus.istek_yaz_i     = 2'b10;
      bus.istek_adres1_i  = 32'h204;
      bus.istek_veri1_i   = 32'h0000AB00;
      bus.istek_maske1_i  = 4'b0010;
      l1c_stall_i         = 1'b1;
      #1;
      kontrol_et("t3_hazir", 64'(bus.istek_hazir_o), 64'h2);
      for (int i = 1; i <= 4; i++) begin
         tik();
         bus.istek_gecerli_i = 2'b00;
         kontrol_et("t3_l1gec", 64'(l1c_istek_gecerli_o), 64'h1);
         kontrol_et("t3_l1yaz", 64'(l1c_yaz_gecerli_o), 64'h1);
         kontrol_et("t3_l1adr", 64'(l1c_veri_adres_o), 64'h204);
         kontrol_et("t3_l1ver", 64'(l1c_yaz_veri_o), 64'h0000AB00);
         kontrol_et("t3_l1msk", 64'(l1c_veri_maske_o), 64'h2);
         kontrol_et("t3_erken", 64'(bus.yanit_gecerli_o), 64'h0);
         if (i == 4) begin
            l1c_stall_i = 1'b0;
         end
      end
      tik();
      bus.istek_yaz_i = 2'b00;
      kontrol_et("t3_yanit", 64'(bus.yanit_gecerli_o), 64'h2);
      kontrol_et("t3_rveri", 64'(bus.yanit_veri_o), 64'h0);
      kontrol_et("t3_l1gec_son", 64'(l1c_istek_gecerli_o), 64'h0);

      // both ports request loads together; port 0 first
      bus.istek_gecerli_i = 2'b11;
      bus.istek_adres0_i  = 32'h300;
      bus.istek_adres1_i  = 32'h400;
      #1;
      kontrol_et("t2_hazir0", 64'(bus.istek_hazir_o), 64'h1);
      tik();
      bus.istek_gecerli_i = 2'b10;
      kontrol_et("t2_l1adr0", 64'(l1c_veri_adres_o), 64'h300);
      kontrol_et("t2_gonder_hazir", 64'(bus.istek_hazir_o), 64'h0);
      tik();
      kontrol_et("t2_bekle_hazir", 64'(bus.istek_hazir_o), 64'h0);
      l1c_oku_gecerli_i = 1'b1;
      l1c_oku_veri_i    = 32'h11111111;
      tik();
      l1c_oku_gecerli_i = 1'b0;
      kontrol_et("t2_yanit0", 64'(bus.yanit_gecerli_o), 64'h1);
      kontrol_et("t2_rveri0", 64'(bus.yanit_veri_o), 64'h11111111);
      #1;
      kontrol_et("t2_hazir1", 64'(bus.istek_hazir_o), 64'h2);
      tik();
      bus.istek_gecerli_i = 2'b00;
      kontrol_et("t2_l1adr1", 64'(l1c_veri_adres_o), 64'h400);
      tik();
      l1c_oku_gecerli_i = 1'b1;
      l1c_oku_veri_i    = 32'h22222222;
      tik();
      l1c_oku_gecerli_i = 1'b0;
      kontrol_et("t2_yanit1", 64'(bus.yanit_gecerli_o), 64'h2);
      kontrol_et("t2_rveri1", 64'(bus.yanit_veri_o), 64'h22222222);
      bus.istek_gecerli_i = 2'b11;
      #1;
      kontrol_et("t2_tur2_hazir", 64'(bus.istek_hazir_o), 64'h1);

      // port-0 load sits in BEKLE for 10 cycles while port 1 requests
      tik();
      bus.istek_gecerli_i = 2'b10;
      kontrol_et("t4_l1adr", 64'(l1c_veri_adres_o), 64'h300);
      for (int i = 0; i < 10; i++) begin
         tik();
         kontrol_et("t4_hazir", 64'(bus.istek_hazir_o), 64'h0);
         kontrol_et("t4_yanit", 64'(bus.yanit_gecerli_o), 64'h0);
         kontrol_et("t4_l1gec", 64'(l1c_istek_gecerli_o), 64'h0);
      end

      // reset while waiting in BEKLE
      rst_i = 1'b1;
      bus.istek_gecerli_i = 2'b00;
      tik();
      hepsi_sifir("t5_rst");
      rst_i = 1'b0;
      l1c_oku_gecerli_i = 1'b1;
      l1c_oku_veri_i    = 32'h33333333;
      tik();
      kontrol_et("t5_artik_yanit", 64'(bus.yanit_gecerli_o), 64'h0);
      kontrol_et("t5_artik_rveri", 64'(bus.yanit_veri_o), 64'h0);

      // tie after reset goes to port 0; stray read-valid in BOSTA/GONDER is ignored
      bus.istek_gecerli_i = 2'b11;
      l1c_oku_veri_i      = 32'h44444444;
      l1c_stall_i         = 1'b1;
      #1;
      kontrol_et("t5_hazir", 64'(bus.istek_hazir_o), 64'h1);
      tik();
      bus.istek_gecerli_i = 2'b10;
      kontrol_et("t6_gonder_yanit", 64'(bus.yanit_gecerli_o), 64'h0);
      kontrol_et("t6_gonder_rveri", 64'(bus.yanit_veri_o), 64'h0);
      kontrol_et("t6_l1adr", 64'(l1c_veri_adres_o), 64'h300);
      tik();
      kontrol_et("t6_gonder2_yanit", 64'(bus.yanit_gecerli_o), 64'h0);
      l1c_stall_i = 1'b0;
      tik();
      kontrol_et("t6_bekle_yanit", 64'(bus.yanit_gecerli_o), 64'h0);
      kontrol_et("t6_bekle_rveri", 64'(bus.yanit_veri_o), 64'h0);
      l1c_oku_veri_i = 32'h55555555;
      tik();
      l1c_oku_gecerli_i = 1'b0;
      kontrol_et("t6_yanit0", 64'(bus.yanit_gecerli_o), 64'h1);
      kontrol_et("t6_rveri0", 64'(bus.yanit_veri_o), 64'h55555555);
      #1;
      kontrol_et("t6_hazir1", 64'(bus.istek_hazir_o), 64'h2);
      tik();
      bus.istek_gecerli_i = 2'b00;
      kontrol_et("t6_l1adr1", 64'(l1c_veri_adres_o), 64'h400);
      tik();
      l1c_oku_gecerli_i = 1'b1;
      l1c_oku_veri_i    = 32'h66666666;
      tik();
      l1c_oku_gecerli_i = 1'b0;
      kontrol_et("t6_yanit1", 64'(bus.yanit_gecerli_o), 64'h2);
      kontrol_et("t6_rveri1", 64'(bus.yanit_veri_o), 64'h66666666);

      $display("%0d/%0d checks passed", gecen, toplam);
      $finish;
   end

endmodule
